// File: rtl/key_loader.sv
// key_loader: assembles a KEY_W-bit key from WORD_W-bit words after a start request with length k.
// Latency: start -> LOAD next cycle; last accepted word -> key_valid_o next cycle; ack -> IDLE next cycle.
// Backpressure: word_ready_o only in LOAD, unbounded word_valid_i stalls; key held in READY until key_ack_i.
//
// Ports:
//   clock_i, reset_i (sync, active-high)       clock and reset
//   start_i, key_lenght_k_i                    load request and key length k (bits), latched on accepted start
//   abort_i                                    cancel load / held key, back to IDLE
//   word_valid_i, word_i, word_ready_o         key word handshake, word j lands at bits [j*WORD_W +: WORD_W]
//   key_o, key_valid_o, key_ack_i              assembled key (bits >= k forced to 0) and its handshake
//   busy_o                                     state is not IDLE
//   error_o                                    one-cycle pulse after a start with k=0 or k>KEY_W
module key_loader #(
  parameter int KEY_W  = 160,
  parameter int WORD_W = 32
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [7:0]        key_lenght_k_i,
  input  logic              abort_i,
  input  logic              word_valid_i,
  input  logic [WORD_W-1:0] word_i,
  output logic              word_ready_o,
  output logic [KEY_W-1:0]  key_o,
  output logic              key_valid_o,
  input  logic              key_ack_i,
  output logic              busy_o,
  output logic              error_o
);

  localparam int NWORDS = KEY_W / WORD_W;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [8:0] KEY_W_L  = 9'(KEY_W);
  localparam logic [8:0] WORD_W_L = 9'(WORD_W);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t             state_q, state_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [7:0]         k_q, k_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;   // index of the final word, N-1
  logic               error_q, error_d;

  logic [8:0]         k_in_ext;
  logic               k_legal;
  logic [KEY_W-1:0]   mask;

  assign k_in_ext = {1'b0, key_lenght_k_i};
  assign k_legal  = (k_in_ext != 9'd0) && (k_in_ext <= KEY_W_L);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      key_q   <= '0;
      k_q     <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    k_d     = k_q;
    idx_d   = idx_q;
    last_d  = last_q;
    error_d = 1'b0;

    // abort beats any simultaneous start, word acceptance or ack
    if (abort_i) begin
      state_d = IDLE;
      key_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if (k_legal) begin
              k_d     = key_lenght_k_i;
              // ceil(k / WORD_W) - 1, k is already known to be in 1..KEY_W
              last_d  = IDX_W'(((k_in_ext + (WORD_W_L - 9'd1)) / WORD_W_L) - 9'd1);
              key_d   = '0;
              idx_d   = '0;
              state_d = LOAD;
            end else begin
              error_d = 1'b1;
            end
          end
        end
        LOAD: begin
          if (word_valid_i) begin
            for (int w = 0; w < NWORDS; w++) begin
              if (idx_q == IDX_W'(w)) key_d[w*WORD_W +: WORD_W] = word_i;
            end
            if (idx_q == last_q) begin
              state_d = READY;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        READY: begin
          if (key_ack_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // bit i of the key is visible only when i < k, which also zeroes the tail of a partial last word
  always_comb begin
    mask = '0;
    for (int i = 0; i < KEY_W; i++) begin
      mask[i] = (9'(i) < {1'b0, k_q});
    end
  end

  assign key_o        = key_q & mask;
  assign word_ready_o = (state_q == LOAD);
  assign key_valid_o  = (state_q == READY);
  assign busy_o       = (state_q != IDLE);
  assign error_o      = error_q;

endmodule

// File: doc/key_loader.md
KEY_LOADER -- requirements
Module: key_loader

Interface
REQ-001 Parameter KEY_W, default 160, maximum key storage width in bits.
REQ-002 Parameter WORD_W, default 32, width of one key-transfer word; KEY_W SHALL be a multiple of WORD_W.
REQ-003 clock_i  input  1  single clock; all state updates on rising edge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 start_i  input  1  request to begin a key load; sampled only in IDLE.
REQ-006 key_lenght_k_i  input  8  key length k in bits; latched on an accepted start.
REQ-007 abort_i  input  1  cancel any load or held key; return to IDLE.
REQ-008 word_valid_i  input  1  key word present on word_i.
REQ-009 word_i  input  WORD_W  key word; first word holds key bits [WORD_W-1:0].
REQ-010 word_ready_o  output  1  block accepts a word this cycle.
REQ-011 key_o  output  KEY_W  assembled key; bits at index >= k forced to 0.
REQ-012 key_valid_o  output  1  key_o complete and stable.
REQ-013 key_ack_i  input  1  consumer has taken key_o.
REQ-014 busy_o  output  1  state is not IDLE.
REQ-015 error_o  output  1  one-cycle pulse on an illegal length.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD and READY.
REQ-017 In IDLE with start_i=1 and 1 <= k <= KEY_W: latch k, set word count N=ceil(k/WORD_W), clear the key register and word index, and enter LOAD next cycle.
REQ-018 In IDLE with start_i=1 and k=0 or k>KEY_W: pulse error_o high for exactly the next cycle and remain in IDLE.
REQ-019 word_ready_o SHALL be 1 only in LOAD; a word is accepted when word_valid_i and word_ready_o are both 1.
REQ-020 Accepted word j (0-based) SHALL be written to key bits [j*WORD_W +: WORD_W]; the word index increments by 1 per accepted word.
REQ-021 On acceptance of word N-1 (cycle t): the FSM enters READY at t+1, and key_valid_o=1 from t+1.
REQ-022 In LOAD, cycles with word_valid_i=0 SHALL not change the index or the key register (unbounded stall allowed).
REQ-023 key_o SHALL be the key register ANDed with a mask whose bit i is 1 iff i < latched k, including partial final words (e.g. k=100: bits 127:100 = 0).
REQ-024 In READY, key_o and key_valid_o SHALL hold until key_ack_i=1; ack in cycle t gives IDLE with key_valid_o=0 at t+1.
REQ-025 key_ack_i outside READY, and start_i outside IDLE, SHALL be ignored.
REQ-026 abort_i=1 in any state SHALL return the FSM to IDLE next cycle with key register, index and key_valid_o cleared.
REQ-027 abort_i SHALL take priority over a simultaneous accepted word, key_ack_i or start_i.
REQ-028 Changes on key_lenght_k_i after the start cycle SHALL have no effect until the next accepted start.
REQ-029 busy_o SHALL equal (state != IDLE).

Reset
REQ-030 With reset_i=1 at a clock edge, the next state SHALL be IDLE, with key register, latched k and index at 0.
REQ-031 During and after reset, the outputs SHALL be word_ready_o=0, key_valid_o=0, busy_o=0, error_o=0 and key_o=0.
REQ-032 reset_i SHALL take priority over abort_i, start_i and all handshakes, including in mid-LOAD.

Verification
REQ-033 k=128, start, words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C sent back-to-back -> key_valid_o=1 one cycle after the 4th word; key_o[127:0]=0x0F0E..00; bits 159:128=0.
REQ-034 k=160 with five words and word_valid_i gaps of 3 cycles -> exactly 5 words accepted; key_valid_o held until key_ack_i, then IDLE next cycle.
REQ-035 k=100, four words of 0xFFFFFFFF -> key_o bits 99:0 = 1, bits 159:100 = 0.
REQ-036 start with k=0, then with k=200 -> error_o pulses once per start; busy_o stays 0; word_ready_o stays 0.
REQ-037 k=128: abort_i asserted together with the 3rd word -> IDLE next cycle, key_o=0; a new k=32 load then completes after 1 word.
REQ-038 reset_i pulsed mid-LOAD after 2 words -> all outputs 0 next cycle; start_i during READY ignored, and the held key_o is unchanged.
